// File: rtl/cpu_pkg.sv
// Shared CPU pipeline types: the IF->OF packet and the fetch-stage in-flight
// tracker entry.
package cpu_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } If_Of_t;

    localparam int INSTR_BYTES = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic        kill;
    } if_infl_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small power-of-two FIFO used for both the in-flight tracker and the fetch
// queue. Each slot carries a kill bit that can be set on all slots at once.
module fetch_fifo #(
    parameter type T     = logic [31:0],
    parameter int  DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  T                       push_data,
    input  logic                   pop,
    input  logic                   flush,
    input  logic                   kill_all,
    output T                       head,
    output logic                   head_kill,
    output logic [$clog2(DEPTH):0] count
);

    localparam int            AW   = $clog2(DEPTH);
    localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);

    T                mem [DEPTH];
    logic [DEPTH-1:0] kill;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (cnt != '0);
    assign do_push = push && ((cnt != FULL) || do_pop);

    // A freshly pushed slot always starts live, even if kill_all fires in the
    // same cycle, since that redirect cannot refer to it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            kill   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            kill   <= '0;
        end else begin
            if (kill_all) begin
                kill <= '1;
            end
            if (do_push) begin
                mem[wr_ptr]  <= push_data;
                kill[wr_ptr] <= 1'b0;
                wr_ptr       <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    assign head      = mem[rd_ptr];
    assign head_kill = kill[rd_ptr];
    assign count     = cnt;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, in-order imem requests with credit-based flow
// control, stale-response killing on redirect, and a registered fetch queue.
module if_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          FQ_DEPTH = 4
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Fetch_En_i,
    output logic        Imem_Req_o,
    output logic [31:0] Imem_Addr_o,
    input  logic        Imem_Gnt_i,
    input  logic        Imem_Rvalid_i,
    input  logic [31:0] Imem_Rdata_i,
    input  logic        Br_Redirect_i,
    input  logic [31:0] Br_Target_i,
    output If_Of_t      If_Payld_o,
    output logic        If_Valid_o,
    input  logic        If_Ready_i
);

    localparam int CW = $clog2(FQ_DEPTH) + 1;

    logic [31:0]   pc;
    logic [CW-1:0] infl_cnt;
    logic [CW-1:0] fq_cnt;
    logic [CW:0]   occupancy;
    logic          credit_ok;
    logic          grant;
    logic          trk_pop;
    logic [31:0]   trk_head;
    logic          trk_kill;
    if_infl_t      infl_head;
    logic          rsp_accept;
    If_Of_t        fq_push_data;
    logic          fq_pop;
    logic          fq_head_kill;

    // Credit uses registered counts only, so every granted request is
    // guaranteed a fetch-queue slot when its response returns.
    assign occupancy  = {1'b0, infl_cnt} + {1'b0, fq_cnt};
    assign credit_ok  = occupancy < (CW+1)'(FQ_DEPTH);
    assign Imem_Req_o = !Rst && Fetch_En_i && !Br_Redirect_i && credit_ok;
    assign Imem_Addr_o = pc;
    assign grant      = Imem_Req_o && Imem_Gnt_i;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            pc <= RESET_PC;
        end else if (Br_Redirect_i) begin
            pc <= Br_Target_i;
        end else if (grant) begin
            pc <= pc + 32'(INSTR_BYTES);
        end
    end

    assign trk_pop   = Imem_Rvalid_i && (infl_cnt != '0);
    assign infl_head = '{pc: trk_head, kill: trk_kill};

    fetch_fifo #(
        .T     (logic [31:0]),
        .DEPTH (FQ_DEPTH)
    ) u_tracker (
        .clk       (Clk),
        .rst       (Rst),
        .push      (grant),
        .push_data (pc),
        .pop       (trk_pop),
        .flush     (1'b0),
        .kill_all  (Br_Redirect_i),
        .head      (trk_head),
        .head_kill (trk_kill),
        .count     (infl_cnt)
    );

    assign rsp_accept   = trk_pop && !infl_head.kill && !Br_Redirect_i;
    assign fq_push_data = '{pc: infl_head.pc, instr: Imem_Rdata_i};
    assign If_Valid_o   = (fq_cnt != '0);
    assign fq_pop       = If_Valid_o && If_Ready_i;

    fetch_fifo #(
        .T     (If_Of_t),
        .DEPTH (FQ_DEPTH)
    ) u_fetch_q (
        .clk       (Clk),
        .rst       (Rst),
        .push      (rsp_accept),
        .push_data (fq_push_data),
        .pop       (fq_pop),
        .flush     (Br_Redirect_i),
        .kill_all  (1'b0),
        .head      (If_Payld_o),
        .head_kill (fq_head_kill),
        .count     (fq_cnt)
    );

    a_rvalid_needs_tracker: assert property (@(posedge Clk) disable iff (Rst)
        Imem_Rvalid_i |-> (infl_cnt != '0));
    a_credit_bound: assert property (@(posedge Clk) disable iff (Rst)
        occupancy <= (CW+1)'(FQ_DEPTH));
    a_fq_never_killed: assert property (@(posedge Clk) disable iff (Rst)
        !fq_head_kill);

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: in-order memory model with configurable latency,
// stimulus driven 1 time unit after posedge, outputs checked on negedge.
module tb_if_stage;
    import cpu_pkg::*;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        Fetch_En_i;
    logic        Imem_Req_o;
    logic [31:0] Imem_Addr_o;
    logic        Imem_Gnt_i;
    logic        Imem_Rvalid_i;
    logic [31:0] Imem_Rdata_i;
    logic        Br_Redirect_i;
    logic [31:0] Br_Target_i;
    If_Of_t      If_Payld_o;
    logic        If_Valid_o;
    logic        If_Ready_i;

    int checkCount = 0;
    int failCount  = 0;
    int memLat     = 1;
    int edgeCnt    = 0;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;
    pend_t pendQ[$];

    if_stage #(
        .RESET_PC (32'h0000_0100),
        .FQ_DEPTH (4)
    ) dut (
        .Clk           (Clk),
        .Rst           (Rst),
        .Fetch_En_i    (Fetch_En_i),
        .Imem_Req_o    (Imem_Req_o),
        .Imem_Addr_o   (Imem_Addr_o),
        .Imem_Gnt_i    (Imem_Gnt_i),
        .Imem_Rvalid_i (Imem_Rvalid_i),
        .Imem_Rdata_i  (Imem_Rdata_i),
        .Br_Redirect_i (Br_Redirect_i),
        .Br_Target_i   (Br_Target_i),
        .If_Payld_o    (If_Payld_o),
        .If_Valid_o    (If_Valid_o),
        .If_Ready_i    (If_Ready_i)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) edgeCnt <= edgeCnt + 1;

    // Decides at each negedge what the memory presents at the next posedge;
    // a grant seen now lands at edge edgeCnt+1 and answers memLat edges later.
    always @(negedge Clk or posedge Rst) begin
        if (Rst) begin
            pendQ.delete();
            Imem_Rvalid_i = 1'b0;
            Imem_Rdata_i  = '0;
        end else begin
            Imem_Rvalid_i = 1'b0;
            Imem_Rdata_i  = '0;
            if (pendQ.size() > 0 && pendQ[0].due == edgeCnt + 1) begin
                Imem_Rvalid_i = 1'b1;
                Imem_Rdata_i  = pendQ[0].addr ^ 32'hA5A5_A5A5;
                void'(pendQ.pop_front());
            end
            if (Imem_Req_o && Imem_Gnt_i) begin
                pendQ.push_back('{addr: Imem_Addr_o, due: edgeCnt + 1 + memLat});
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic fetchEn, input logic ready,
                                 input logic redirect, input logic [31:0] target);
        @(posedge Clk);
        #1;
        Fetch_En_i    = fetchEn;
        If_Ready_i    = ready;
        Br_Redirect_i = redirect;
        Br_Target_i   = target;
        @(negedge Clk);
    endtask

    task automatic nextCycle();
        @(negedge Clk);
    endtask

    task automatic doReset(input int lat);
        Rst    = 1'b1;
        memLat = lat;
        @(posedge Clk);
        #1;
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        @(negedge Clk);
    endtask

    task automatic checkHead(input string tag, input logic [31:0] expPc);
        checkOutput({tag, "_valid"}, 32'(If_Valid_o), 32'd1);
        checkOutput({tag, "_pc"}, If_Payld_o.pc, expPc);
        checkOutput({tag, "_instr"}, If_Payld_o.instr, expPc ^ 32'hA5A5_A5A5);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        Rst           = 1'b1;
        Fetch_En_i    = 1'b1;
        If_Ready_i    = 1'b1;
        Br_Redirect_i = 1'b0;
        Br_Target_i   = '0;
        Imem_Gnt_i    = 1'b1;
        #2;
        checkOutput("rst_req", 32'(Imem_Req_o), 32'd0);
        checkOutput("rst_valid", 32'(If_Valid_o), 32'd0);
        checkOutput("rst_payld_pc", If_Payld_o.pc, 32'd0);
        checkOutput("rst_payld_instr", If_Payld_o.instr, 32'd0);
        checkOutput("rst_addr", Imem_Addr_o, 32'h100);

        // Reset release, 1-cycle memory: first packet two cycles after first grant
        doReset(1);
        checkOutput("rel_addr_n1", Imem_Addr_o, 32'h100);
        checkOutput("rel_req_n1", 32'(Imem_Req_o), 32'd1);
        checkOutput("rel_valid_n1", 32'(If_Valid_o), 32'd0);
        nextCycle();
        checkOutput("rel_addr_n2", Imem_Addr_o, 32'h104);
        checkOutput("rel_valid_n2", 32'(If_Valid_o), 32'd0);
        for (int k = 3; k <= 7; k++) begin
            nextCycle();
            checkHead($sformatf("stream_n%0d", k), 32'h100 + 32'(4 * (k - 3)));
            checkOutput($sformatf("stream_addr_n%0d", k), Imem_Addr_o,
                        32'h100 + 32'(4 * (k - 1)));
        end

        // Backpressure for 10 cycles: issue stops once credit is exhausted
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        for (int k = 8; k <= 17; k++) begin
            checkHead($sformatf("bp_n%0d", k), 32'h114);
            checkOutput($sformatf("bp_req_n%0d", k), 32'(Imem_Req_o),
                        (k < 10) ? 32'd1 : 32'd0);
            if (k < 17) nextCycle();
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("drain_req_n18", 32'(Imem_Req_o), 32'd0);
        for (int k = 18; k <= 24; k++) begin
            checkHead($sformatf("drain_n%0d", k), 32'h114 + 32'(4 * (k - 18)));
            if (k == 19) begin
                checkOutput("drain_req_n19", 32'(Imem_Req_o), 32'd1);
                checkOutput("drain_addr_n19", Imem_Addr_o, 32'h124);
            end
            if (k < 24) nextCycle();
        end

        // Asynchronous reset in the middle of streaming
        #2;
        Rst = 1'b1;
        #1;
        checkOutput("midrst_req", 32'(Imem_Req_o), 32'd0);
        checkOutput("midrst_valid", 32'(If_Valid_o), 32'd0);
        checkOutput("midrst_pc", If_Payld_o.pc, 32'd0);
        checkOutput("midrst_instr", If_Payld_o.instr, 32'd0);

        // Latency 3, redirect with two requests outstanding
        doReset(3);
        checkOutput("midrst_addr_after", Imem_Addr_o, 32'h100);
        checkOutput("lat3_req_n1", 32'(Imem_Req_o), 32'd1);
        nextCycle();
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h2000);
        checkOutput("redir_req_low", 32'(Imem_Req_o), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("redir_req_n4", 32'(Imem_Req_o), 32'd1);
        checkOutput("redir_addr_n4", Imem_Addr_o, 32'h2000);
        checkOutput("redir_valid_n4", 32'(If_Valid_o), 32'd0);
        for (int k = 5; k <= 7; k++) begin
            nextCycle();
            checkOutput($sformatf("redir_drain_valid_n%0d", k), 32'(If_Valid_o), 32'd0);
        end
        nextCycle();
        checkHead("redir_first", 32'h2000);

        // Redirect coinciding with a response and an OF pop
        doReset(1);
        nextCycle();
        nextCycle();
        nextCycle();
        checkHead("simul_pre", 32'h104);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h3000);
        checkOutput("simul_req", 32'(Imem_Req_o), 32'd0);
        checkHead("simul_head", 32'h108);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("simul_flushed", 32'(If_Valid_o), 32'd0);
        checkOutput("simul_addr", Imem_Addr_o, 32'h3000);
        checkOutput("simul_req_after", 32'(Imem_Req_o), 32'd1);
        nextCycle();
        checkOutput("simul_valid_n7", 32'(If_Valid_o), 32'd0);
        nextCycle();
        checkHead("simul_first", 32'h3000);
        nextCycle();
        checkHead("simul_second", 32'h3004);

        // Back-to-back redirects: only the second target is fetched
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h40);
        checkOutput("b2b_req_n10", 32'(Imem_Req_o), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h80);
        checkOutput("b2b_req_n11", 32'(Imem_Req_o), 32'd0);
        checkOutput("b2b_valid_n11", 32'(If_Valid_o), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("b2b_addr_n12", Imem_Addr_o, 32'h80);
        checkOutput("b2b_valid_n12", 32'(If_Valid_o), 32'd0);
        nextCycle();
        checkOutput("b2b_valid_n13", 32'(If_Valid_o), 32'd0);
        nextCycle();
        checkHead("b2b_first", 32'h80);
        nextCycle();
        checkHead("b2b_second", 32'h84);

        // PC wrap at the top of the address space
        applyStimulus(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("wrap_addr_top", Imem_Addr_o, 32'hFFFF_FFFC);
        checkOutput("wrap_req", 32'(Imem_Req_o), 32'd1);
        nextCycle();
        checkOutput("wrap_addr_zero", Imem_Addr_o, 32'h0000_0000);
        nextCycle();
        checkHead("wrap_pkt_top", 32'hFFFF_FFFC);
        nextCycle();
        checkHead("wrap_pkt_zero", 32'h0000_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage. It owns the PC, issues in-order requests to the instruction memory, and tracks outstanding requests so that stale responses are discarded after a branch redirect. It buffers returned instructions in a fetch queue and presents them to the operand-fetch stage as `If_Of_t` packets over a valid/ready handshake. It is the producer side of the IF→OF interface.

## Interface
Parameters:
- `RESET_PC`, default `32'h0000_0000`: PC loaded at reset.
- `FQ_DEPTH`, default `4`: depth of the fetch queue and of the in-flight tracker. Must be a power of two and ≥2.

Ports:
- `Clk`, in, 1: the single clock.
- `Rst`, in, 1: asynchronous, active-high reset.
- `Fetch_En_i`, in, 1: global fetch enable. When low, no new requests are issued.
- `Imem_Req_o`, out, 1: request valid.
- `Imem_Addr_o`, out, 32: request byte address. Equals the current PC.
- `Imem_Gnt_i`, in, 1: request accepted. Only meaningful when `Imem_Req_o` is high.
- `Imem_Rvalid_i`, in, 1: response valid. Responses return in order, at least 1 cycle after grant.
- `Imem_Rdata_i`, in, 32: instruction word.
- `Br_Redirect_i`, in, 1: redirect strobe from EX, one cycle wide.
- `Br_Target_i`, in, 32: redirect target PC.
- `If_Payld_o`, out, `If_Of_t`: `{pc, instr}` at the head of the fetch queue.
- `If_Valid_o`, out, 1: head valid.
- `If_Ready_i`, in, 1: OF accepts the head.

## Operation
- **PC register.** Reset value is `RESET_PC`.
  - On grant (`Imem_Req_o && Imem_Gnt_i`): PC ← PC + 4. Wraps modulo 2^32.
  - On `Br_Redirect_i`: PC ← `Br_Target_i`. This has priority over grant.
- **Request.**
  - `Imem_Req_o = Fetch_En_i && !Br_Redirect_i && (infl_cnt + fq_cnt < FQ_DEPTH)`.
  - Both counts are registered values. There is no combinational path from `If_Ready_i` or `Imem_Rvalid_i` to `Imem_Req_o`.
  - Once asserted, `Imem_Req_o` and `Imem_Addr_o` hold until grant, unless a redirect or `Fetch_En_i` drop intervenes.
- **In-flight tracker.** FIFO of `{pc, kill}` entries, `FQ_DEPTH` deep.
  - Push `{PC, 0}` on grant.
  - Pop on `Imem_Rvalid_i`.
  - On `Br_Redirect_i`, set `kill` on every valid entry.
- **Response handling.**
  - On `Imem_Rvalid_i`, if the popped entry has `kill = 0` and there is no redirect this cycle, push `{pc, Imem_Rdata_i}` into the fetch queue.
  - Otherwise, drop the response.
  - `Imem_Rvalid_i` with an empty tracker is a protocol error. Ignore it and assert it in simulation.
- **Fetch queue.**
  - `If_Valid_o = (fq_cnt != 0)`.
  - `If_Payld_o` = head entry.
  - Pop when `If_Valid_o && If_Ready_i`.
  - Simultaneous push and pop leaves `fq_cnt` unchanged.
- **Redirect.** Flushes the fetch queue in the same cycle: `fq_cnt` ← 0 and `If_Valid_o` is low next cycle. A same-cycle pop is discarded with the rest.
- **Credit invariant.** `infl_cnt + fq_cnt ≤ FQ_DEPTH` at all times, so a response always has a slot.
- **`Fetch_En_i` deassertion.** Stops new requests only. Outstanding responses still complete and are queued.

## Timing
- **Reset values:** `Imem_Req_o` = 0, `If_Valid_o` = 0, `If_Payld_o` = 0. PC = `RESET_PC`. All counts and kill bits are 0.
- **Reset mid-operation:** everything clears asynchronously. Responses arriving after reset release with an empty tracker are ignored.
- **Latency:** grant at cycle N, `Rvalid` at N+1, `If_Valid_o` at N+2. The fetch queue is registered and has no bypass.
- **Throughput:** 1 instruction/cycle sustained with 1-cycle memory latency and `FQ_DEPTH` = 4.
- **Redirect:**
  - Asserted at cycle N: `Imem_Req_o` is low in cycle N.
  - First request to the target is at N+1 if credit allows.
  - Killed responses drain without reaching OF.
- **Full queue:** `If_Ready_i` held low stalls issue once `infl_cnt + fq_cnt = FQ_DEPTH`. Issue resumes the cycle after the first pop.

## Structure
- **`cpu_pkg`:**
  - Reuse `If_Of_t` (`pc[31:0]`, `instr[31:0]`).
  - Add `localparam INSTR_BYTES = 4` and `typedef struct packed {logic [31:0] pc; logic kill;} if_infl_t`.
- **Sub-module `fetch_fifo`:**
  - Parameterized type `T` and `DEPTH`.
  - Ports: push, pop, flush, `count` output.
  - The in-flight tracker additionally needs a set-all-kill input.
  - Instantiated twice: tracker and fetch queue.

## Test plan
- **Reset release.** `RESET_PC=0x100`, `Fetch_En_i=1`, always-grant memory with 1-cycle latency returning `instr=addr^0xA5A5A5A5`, `If_Ready_i=1` → `Imem_Addr_o` = 0x100, 0x104, 0x108, ….
  - First `If_Valid_o` 2 cycles after first grant.
  - Thereafter 1 packet/cycle with matching pc/instr.
- **Backpressure.** `If_Ready_i=0` for 10 cycles → at most 4 outstanding plus queued. `Imem_Req_o` goes low.
  - On release, packets drain in order with no loss or duplication.
- **Redirect with in-flight responses.** Memory latency 3, redirect to 0x2000 while 2 requests are outstanding → both stale responses are dropped.
  - The next OF packet has pc = 0x2000.
  - The queue is empty the cycle after the redirect.
- **Simultaneous events.** Redirect in the same cycle as `Rvalid` and as an OF pop → the response is dropped and the queue is flushed. No grant occurs that cycle.
- **Back-to-back redirects.** Redirects at N and N+1 (targets 0x40, 0x80) → the first packet's pc is 0x80. No 0x40 packet appears.
- **Wrap and mid-run reset.** PC wraps: start at 0xFFFF_FFFC → the next address is 0x0000_0000.
  - Async `Rst` mid-run → outputs are 0 immediately and `Imem_Addr_o` = `RESET_PC` after release.
